// File: rtl/smbus_tx_sequencer.sv
// smbus_tx_sequencer: drains a TX FIFO into an SMBus byte engine, one byte per handshake.
// Ports: clk/rst; start/xfer_len/abort (control); fifo_* (TX FIFO pop side); byte_* (engine side);
//        busy/done/error/err_code/bytes_sent (status).
// Latency: start -> first byte_valid 2 cycles; ACK -> next byte_valid 2 cycles (non-empty FIFO).
// Backpressure: a byte is held on byte_data until byte_ready; an empty FIFO stalls FETCH until STALL_TIMEOUT.
module smbus_tx_sequencer #(
    parameter int DATA_WIDTH    = 8,
    parameter int LEN_WIDTH     = 8,
    parameter int STALL_TIMEOUT = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [LEN_WIDTH-1:0]  xfer_len,
    input  logic                  abort,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    input  logic                  fifo_empty,
    output logic                  byte_valid,
    output logic [DATA_WIDTH-1:0] byte_data,
    input  logic                  byte_ready,
    input  logic                  byte_nack,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [1:0]            err_code,
    output logic [LEN_WIDTH-1:0]  bytes_sent
);

    // The stall counter only ever needs to reach STALL_TIMEOUT-1.
    localparam int STALL_W = (STALL_TIMEOUT > 1) ? $clog2(STALL_TIMEOUT) : 1;
    localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(STALL_TIMEOUT - 1);

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_NACK     = 2'b01;
    localparam logic [1:0] ERR_UNDERRUN = 2'b10;
    localparam logic [1:0] ERR_ABORT    = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_SEND,
        S_DONE,
        S_ERR
    } state_t;

    state_t                state_q, state_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic [LEN_WIDTH-1:0]  sent_q, sent_d;
    logic [LEN_WIDTH-1:0]  sent_inc;
    logic [STALL_W-1:0]    stall_q, stall_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [1:0]            code_q, code_d;
    logic                  rd_en;

    assign sent_inc = sent_q + LEN_WIDTH'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            sent_q  <= '0;
            stall_q <= '0;
            data_q  <= '0;
            code_q  <= ERR_NONE;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            sent_q  <= sent_d;
            stall_q <= stall_d;
            data_q  <= data_d;
            code_q  <= code_d;
        end
    end

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        sent_d  = sent_q;
        stall_d = '0;
        data_d  = data_q;
        code_d  = code_q;
        rd_en   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    len_d   = xfer_len;
                    sent_d  = '0;
                    code_d  = ERR_NONE;
                    state_d = (xfer_len == '0) ? S_DONE : S_FETCH;
                end
            end
            S_FETCH: begin
                // Abort outranks both the pop and the stall timeout.
                if (abort) begin
                    code_d  = ERR_ABORT;
                    state_d = S_ERR;
                end else if (!fifo_empty) begin
                    rd_en   = 1'b1;
                    data_d  = fifo_rd_data;
                    state_d = S_SEND;
                end else if (stall_q == STALL_LAST) begin
                    code_d  = ERR_UNDERRUN;
                    state_d = S_ERR;
                end else begin
                    stall_d = stall_q + STALL_W'(1);
                end
            end
            S_SEND: begin
                // An aborted in-flight byte is not counted even if ACKed this cycle.
                if (abort) begin
                    code_d  = ERR_ABORT;
                    state_d = S_ERR;
                end else if (byte_ready) begin
                    if (byte_nack) begin
                        code_d  = ERR_NACK;
                        state_d = S_ERR;
                    end else begin
                        // sent_q < len_q here, so the increment can never wrap.
                        sent_d  = sent_inc;
                        state_d = (sent_inc == len_q) ? S_DONE : S_FETCH;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Gate the pop with rst so a reset landing in FETCH never consumes a byte.
    assign fifo_rd_en = rd_en & ~rst;
    assign byte_valid = (state_q == S_SEND);
    assign byte_data  = data_q;
    assign busy       = (state_q == S_FETCH) || (state_q == S_SEND);
    assign done       = (state_q == S_DONE);
    assign error      = (state_q == S_ERR);
    assign err_code   = code_q;
    assign bytes_sent = sent_q;

endmodule
